mant_mul_seq: RTL and testbench

Sequential shift-and-add unsigned mantissa multiplier for the floating-point multiply datapath.
- Accepts two 21-bit mantissas (hidden bit included) over a valid/ready handshake.
- Builds the 42-bit product by 21 iterations of conditional add through the existing 42-bit ripple-carry adder `add_42bits`.
- Presents the product downstream to the normalize/round stage over a second valid/ready handshake.

---
 rtl/mant_mul_seq_if.sv | 22 ++
 rtl/mant_mul_seq.sv | 109 ++++++++++
 tb/tb_mant_mul_seq.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/mant_mul_seq_if.sv
// Operand and product handshakes of the sequential mantissa multiplier.
// Upstream drives i_valid/i_mant_*; downstream drives i_ready.
interface mant_mul_seq_if #(parameter int WIDTH = 21);
  logic               i_valid;
  logic               o_ready;
  logic [WIDTH-1:0]   i_mant_a;
  logic [WIDTH-1:0]   i_mant_b;
  logic               o_valid;
  logic               i_ready;
  logic [2*WIDTH-1:0] o_product;
  logic               o_busy;

  modport master (
    output i_valid, i_mant_a, i_mant_b, i_ready,
    input  o_ready, o_valid, o_product, o_busy
  );

  modport slave (
    input  i_valid, i_mant_a, i_mant_b, i_ready,
    output o_ready, o_valid, o_product, o_busy
  );
endinterface

// File: rtl/mant_mul_seq.sv
// Purpose: unsigned 21x21 shift-and-add mantissa multiplier, 42-bit product.
// Latency: 21 cycles from operand accept to o_valid; one op per 23 cycles max.
// Backpressure: DONE holds product and o_valid until i_ready; inputs ignored outside IDLE.
module add_42bits (
  input  logic [41:0] a,
  input  logic [41:0] b,
  input  logic        ci,
  output logic [41:0] s,
  output logic        co
);
  logic [42:0] c;

  assign c[0] = ci;
  for (genvar i = 0; i < 42; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign co = c[42];
endmodule

module mant_mul_seq (
  input  logic          i_clk,
  input  logic          i_rst_n,
  mant_mul_seq_if.slave bus
);
  localparam int WIDTH = 21;
  localparam int PW    = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [PW-1:0]    mcand;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    sum;
  logic [PW-1:0]    acc_nxt;
  logic [PW-1:0]    product_q;
  logic [WIDTH-1:0] mplier;
  logic [4:0]       cnt;
  logic             add_co;
  logic             last;

  add_42bits u_add (
    .a  (acc),
    .b  (mcand),
    .ci (1'b0),
    .s  (sum),
    .co (add_co)
  );

  assign acc_nxt = mplier[0] ? sum : acc;
  assign last    = (cnt == 5'(WIDTH - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.i_valid) state_nxt = CALC;
      CALC:    if (last)        state_nxt = DONE;
      DONE:    if (bus.i_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.o_ready = (state == IDLE);
    bus.o_busy  = (state == CALC);
    bus.o_valid = (state == DONE);
  end

  // Product register is only reloaded at the end of CALC, so it survives the return to IDLE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
      product_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_valid) begin
            mcand  <= {{WIDTH{1'b0}}, bus.i_mant_a};
            mplier <= bus.i_mant_b;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        CALC: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 5'd1;
          if (last) product_q <= acc_nxt;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_product = product_q;

  // The partial sum can never exceed (2^21-1)^2, so the adder carry-out stays low in CALC.
  assert property (@(posedge i_clk) disable iff (!i_rst_n) (state == CALC) |-> !add_co);
endmodule

// File: tb/tb_mant_mul_seq.sv
// Scoreboard bench for mant_mul_seq: directed vectors, backpressure, reset abort, random stream.
module tb_mant_mul_seq;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   n_tx  = 0;
  int   n_rx  = 0;
  logic co_seen  = 1'b0;
  logic rand_rdy = 1'b0;
  logic [41:0] exp_q[$];
  logic [41:0] mon_exp;

  mant_mul_seq_if bus ();

  mant_mul_seq dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [41:0] act, input logic [41:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Transfer happens at the next rising edge; sample here on the falling edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.o_valid === 1'b1 && bus.i_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_product: got %h expected none", bus.o_product);
      end else begin
        mon_exp = exp_q.pop_front();
        check("product", bus.o_product, mon_exp);
        n_rx++;
      end
    end
    if (bus.o_busy === 1'b1 && dut.add_co === 1'b1) co_seen = 1'b1;
  end

  always @(posedge clk) begin
    #2;
    if (rand_rdy) bus.i_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic send(input logic [20:0] a, input logic [20:0] b, input logic [41:0] exp);
    int ok;
    ok = 0;
    bus.i_valid  = 1'b1;
    bus.i_mant_a = a;
    bus.i_mant_b = b;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (bus.o_ready) begin
        ok = 1;
        break;
      end
    end
    if (ok == 0) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got no accept expected accept");
      bus.i_valid = 1'b0;
    end else begin
      @(posedge clk);
      exp_q.push_back(exp);
      n_tx++;
      #1;
      bus.i_valid = 1'b0;
    end
  endtask

  // Called at accept edge + 1; counts cycles to o_valid and busy samples on the way.
  task automatic wait_valid(output int lat, output int busy_cnt);
    lat = -1;
    busy_cnt = bus.o_busy ? 1 : 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (bus.o_busy) busy_cnt++;
      if (bus.o_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic directed(input string name, input logic [20:0] a, input logic [20:0] b,
                          input logic [41:0] exp);
    int lat, bc;
    send(a, b, exp);
    wait_valid(lat, bc);
    check({name, "_latency"}, 42'(lat), 42'd21);
    check({name, "_busy_cycles"}, 42'(bc), 42'd21);
    @(posedge clk);
    #1;
    check({name, "_ready_after"}, 42'(bus.o_ready), 42'd1);
    check({name, "_valid_after"}, 42'(bus.o_valid), 42'd0);
  endtask

  initial begin
    int lat, bc, vcnt, gap;
    logic [20:0] ra, rb;
    logic [41:0] rp;

    rst_n        = 1'b1;
    bus.i_valid  = 1'b0;
    bus.i_mant_a = '0;
    bus.i_mant_b = '0;
    bus.i_ready  = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_o_ready", 42'(bus.o_ready), 42'd1);
    check("rst_o_valid", 42'(bus.o_valid), 42'd0);
    check("rst_o_busy", 42'(bus.o_busy), 42'd0);
    check("rst_o_product", bus.o_product, 42'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    directed("one_x_one", 21'h000001, 21'h000001, 42'h00000000001);
    directed("max_x_max", 21'h1FFFFF, 21'h1FFFFF, 42'h3FFFFC00001);
    directed("one5_x_one5", 21'h180000, 21'h180000, 42'h24000000000);
    directed("zero_x_b", 21'h000000, 21'h012345, 42'h00000000000);

    // Backpressure: DONE held while inputs wiggle.
    bus.i_ready = 1'b0;
    send(21'd2, 21'd7, 42'h0000000000E);
    wait_valid(lat, bc);
    check("bp_latency", 42'(lat), 42'd21);
    for (int k = 0; k < 5; k++) begin
      bus.i_valid  = k[0];
      bus.i_mant_a = 21'($urandom);
      bus.i_mant_b = 21'($urandom);
      @(posedge clk);
      #1;
      check("bp_product", bus.o_product, 42'h0000000000E);
      check("bp_valid", 42'(bus.o_valid), 42'd1);
      check("bp_ready", 42'(bus.o_ready), 42'd0);
    end
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_ready_next", 42'(bus.o_ready), 42'd1);
    check("bp_valid_next", 42'(bus.o_valid), 42'd0);
    check("bp_product_kept", bus.o_product, 42'h0000000000E);

    // Reset at CALC iteration 10 aborts the operation.
    send(21'h0ABCDE, 21'h000777, 42'h0);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    void'(exp_q.pop_back());
    n_tx--;
    check("abort_o_ready", 42'(bus.o_ready), 42'd1);
    check("abort_o_valid", 42'(bus.o_valid), 42'd0);
    check("abort_o_busy", 42'(bus.o_busy), 42'd0);
    check("abort_o_product", bus.o_product, 42'h0);
    check("abort_acc", dut.acc, 42'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    vcnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (bus.o_valid) vcnt++;
    end
    check("abort_no_valid", 42'(vcnt), 42'd0);
    directed("three_x_five", 21'd3, 21'd5, 42'h0000000000F);

    // Random stream with random gaps and random downstream ready.
    rand_rdy = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      ra = 21'($urandom);
      rb = 21'($urandom);
      if (n % 10 == 0) ra = 21'h1FFFFF;
      rp = {21'b0, ra} * {21'b0, rb};
      gap = $urandom_range(0, 3);
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
      send(ra, rb, rp);
    end
    for (int k = 0; k < 2000 && exp_q.size() != 0; k++) @(posedge clk);
    rand_rdy = 1'b0;
    #3;
    bus.i_ready = 1'b1;
    check("queue_drained", 42'(exp_q.size()), 42'd0);
    check("rx_count", 42'(n_rx), 42'(n_tx));
    check("carry_out_never", 42'(co_seen), 42'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
